// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot/Julia escape-time engine.
package mandel_pkg;

    localparam int unsigned DEF_WIDTH  = 27;
    localparam int unsigned DEF_FRAC   = 23;
    localparam int unsigned DEF_ITER_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    // Escape threshold 4.0 in the fixed-point format; callers cast to WIDTH+1 bits.
    function automatic logic [63:0] four_const(input int unsigned frac);
        return 64'd4 << frac;
    endfunction

endpackage

// File: rtl/mandel_fx_mult.sv
// Signed fixed-point multiply: full-width product, truncated to the operand
// format, saturated to max/min with a sat flag on overflow.
module mandel_fx_mult #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned FRAC  = 23
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p,
    output logic                    sat
);

    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] full;
    logic        [WIDTH-FRAC:0] upper;
    logic                       frac_unused;

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign full  = a_ext * b_ext;

    // Bits above the kept window must all equal its sign bit, else overflow.
    assign upper       = full[2*WIDTH-1:FRAC+WIDTH-1];
    assign frac_unused = ^full[FRAC-1:0];

    always_comb begin
        sat = !((upper == '0) || (upper == '1));
        if (sat)
            p = full[2*WIDTH-1] ? SMIN : SMAX;
        else
            p = full[FRAC+WIDTH-1:FRAC];
    end

endmodule

// File: rtl/mandel_iter_engine.sv
// Escape-time engine: iterates z <- z^2 + c one step per clock for one point
// per valid/ready transaction and returns the count, escape flag and tag.
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned FRAC   = DEF_FRAC,
    parameter int unsigned ITER_W = DEF_ITER_W,
    parameter int unsigned TAG_W  = 20
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_cr,
    input  logic signed [WIDTH-1:0] in_ci,
    input  logic signed [WIDTH-1:0] in_zr0,
    input  logic signed [WIDTH-1:0] in_zi0,
    input  logic [ITER_W-1:0]       in_max_iter,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ITER_W-1:0]       out_iter,
    output logic                    out_escaped,
    output logic [TAG_W-1:0]        out_tag
);

    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0]   FOUR = (WIDTH+1)'(four_const(FRAC));

    state_t                  state;
    logic signed [WIDTH-1:0] cr, ci, zr, zi;
    logic [ITER_W-1:0]       max_iter, count;
    logic [TAG_W-1:0]        tag;

    logic signed [WIDTH-1:0] zr2, zi2, zx;
    logic                    zr2_sat, zi2_sat, zx_sat_unused;
    logic signed [WIDTH:0]   sum_sq, diff, dbl;
    logic signed [WIDTH-1:0] diff_c, dbl_c, next_zr, next_zi;
    logic                    esc;

    function automatic logic signed [WIDTH-1:0] clip(input logic signed [WIDTH:0] s);
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? SMIN : SMAX;
        return s[WIDTH-1:0];
    endfunction

    mandel_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sq_r (
        .a(zr), .b(zr), .p(zr2), .sat(zr2_sat)
    );
    mandel_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sq_i (
        .a(zi), .b(zi), .p(zi2), .sat(zi2_sat)
    );
    // A saturated cross product always saturates again when doubled, so its flag adds nothing.
    mandel_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_cross (
        .a(zr), .b(zi), .p(zx), .sat(zx_sat_unused)
    );

    always_comb begin
        sum_sq  = {zr2[WIDTH-1], zr2} + {zi2[WIDTH-1], zi2};
        esc     = zr2_sat || zi2_sat || (sum_sq > FOUR);
        diff    = {zr2[WIDTH-1], zr2} - {zi2[WIDTH-1], zi2};
        diff_c  = clip(diff);
        next_zr = clip({diff_c[WIDTH-1], diff_c} + {cr[WIDTH-1], cr});
        dbl     = {zx, 1'b0};
        dbl_c   = clip(dbl);
        next_zi = clip({dbl_c[WIDTH-1], dbl_c} + {ci[WIDTH-1], ci});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            out_tag     <= '0;
            cr          <= '0;
            ci          <= '0;
            zr          <= '0;
            zi          <= '0;
            max_iter    <= '0;
            count       <= '0;
            tag         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cr       <= in_cr;
                        ci       <= in_ci;
                        zr       <= in_zr0;
                        zi       <= in_zi0;
                        max_iter <= in_max_iter;
                        tag      <= in_tag;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= ITER;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ITER: begin
                    if (abort) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else if ((count == max_iter) || esc) begin
                        out_iter    <= count;
                        out_escaped <= esc;
                        out_tag     <= tag;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        zr    <= next_zr;
                        zi    <= next_zi;
                        count <= count + ITER_W'(1);
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Self-checking bench for mandel_iter_engine against an integer escape-time model.
module tb_mandel_iter_engine;

    localparam int W  = 27;
    localparam int F  = 23;
    localparam int IW = 16;
    localparam int TW = 20;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));
    localparam longint ONE  = 64'sd1 <<< F;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_cr = '0, in_ci = '0, in_zr0 = '0, in_zi0 = '0;
    logic [IW-1:0]       in_max_iter = '0;
    logic [TW-1:0]       in_tag = '0;
    logic                abort = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [IW-1:0]       out_iter;
    logic                out_escaped;
    logic [TW-1:0]       out_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mandel_iter_engine #(.WIDTH(W), .FRAC(F), .ITER_W(IW), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cr(in_cr), .in_ci(in_ci), .in_zr0(in_zr0), .in_zi0(in_zi0),
        .in_max_iter(in_max_iter), .in_tag(in_tag), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .out_escaped(out_escaped), .out_tag(out_tag)
    );

    function automatic longint clampv(input longint v);
        return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    endfunction

    // Escape-time reference: plain integer arithmetic on the real-valued recurrence.
    function automatic void model(input longint cr, ci, zr0, zi0, input int mx,
                                  output int it, output bit esc);
        longint zr = zr0, zi = zi0, sr, si, x, nr;
        it = 0;
        while (1) begin
            sr  = (zr * zr) >>> F;
            si  = (zi * zi) >>> F;
            esc = (sr > MAXV) || (si > MAXV) || (clampv(sr) + clampv(si) > 4 * ONE);
            if (esc || it == mx) break;
            x  = clampv((zr * zi) >>> F);
            nr = clampv(clampv(clampv(sr) - clampv(si)) + cr);
            zi = clampv(clampv(2 * x) + ci);
            zr = nr;
            it++;
        end
    endfunction

    function automatic longint rnd_fx(input longint lim);
        return longint'($urandom_range(0, 32'(2 * lim))) - lim;
    endfunction

    task automatic drive_point(input longint cr, ci, zr, zi, input int mx, input logic [TW-1:0] tg);
        in_cr = cr[W-1:0]; in_ci = ci[W-1:0];
        in_zr0 = zr[W-1:0]; in_zi0 = zi[W-1:0];
        in_max_iter = IW'(mx); in_tag = tg;
    endtask

    // Waits (bounded) for in_ready, then presents the point for exactly one accept edge.
    task automatic send(input longint cr, ci, zr, zi, input int mx, input logic [TW-1:0] tg,
                        output bit ok);
        int n = 0;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        ok = in_ready;
        drive_point(cr, ci, zr, zi, mx, tg);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int bound, output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < bound) begin @(posedge clk); #1; lat++; end
        ok = out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_iter !== '0 ||
            out_escaped !== 1'b0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b iter=%0d esc=%b tag=%h required 0/0/0/0/0",
                     in_ready, out_valid, out_iter, out_escaped, out_tag);
        end
        #19 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release in_ready=%b required 1", in_ready);
        end
    endtask

    // Directed points: bounded orbit, 4.0 boundary, periodic -2, product saturation.
    task automatic test_directed();
        longint cr_t[4] = '{0, ONE, -2 * ONE, (15 * ONE) / 2};
        int     mx_t[4] = '{100, 100, 50, 100};
        int     it_t[4] = '{100, 3, 50, 1};
        bit     es_t[4] = '{0, 1, 0, 1};
        logic [TW-1:0] tg;
        int lat; bit ok, okr;
        for (int i = 0; i < 4; i++) begin
            tg = (i == 3) ? 20'h5A5A5 : TW'(i + 1);
            send(cr_t[i], 0, 0, 0, mx_t[i], tg, ok);
            wait_result(200, lat, okr);
            checks++;
            if (!ok || !okr) begin
                errors++; $display("FAIL directed_timeout[%0d] accept=%b result=%b required 1/1", i, ok, okr);
            end
            checks++;
            if (int'(out_iter) !== it_t[i] || out_escaped !== es_t[i] || out_tag !== tg) begin
                errors++;
                $display("FAIL directed[%0d] iter=%0d esc=%b tag=%h required %0d/%b/%h",
                         i, out_iter, out_escaped, out_tag, it_t[i], es_t[i], tg);
            end
            if (i == 0) begin
                // Edges after the accept edge; the accept cycle itself makes it max+2 cycles.
                checks++;
                if (lat !== 101) begin
                    errors++; $display("FAIL latency edges=%0d required 101", lat);
                end
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat, it; bit ok, okr, esc;
        logic [IW-1:0] h_it; logic h_es; logic [TW-1:0] h_tg;
        send((15 * ONE) / 2, 0, 0, 0, 100, 20'h5A5A5, ok);
        wait_result(50, lat, okr);
        h_it = out_iter; h_es = out_escaped; h_tg = out_tag;
        checks++;
        if (!okr || h_tg !== 20'h5A5A5 || h_it !== IW'(1) || h_es !== 1'b1) begin
            errors++; $display("FAIL bp_result iter=%0d esc=%b tag=%h required 1/1/5a5a5", h_it, h_es, h_tg);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_iter !== h_it ||
                out_escaped !== h_es || out_tag !== h_tg) begin
                errors++;
                $display("FAIL bp_hold[%0d] vld=%b rdy=%b iter=%0d esc=%b tag=%h required 1/0/%0d/%b/%h",
                         c, out_valid, in_ready, out_iter, out_escaped, out_tag, h_it, h_es, h_tg);
            end
        end
        drive_point(ONE / 4, ONE / 2, 0, 0, 30, 20'h00777);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release vld=%b rdy=%b required 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_next_accept in_ready=%b required 0", in_ready);
        end
        model(ONE / 4, ONE / 2, 0, 0, 30, it, esc);
        wait_result(60, lat, okr);
        checks++;
        if (!okr || int'(out_iter) !== it || out_escaped !== esc || out_tag !== 20'h00777) begin
            errors++; $display("FAIL bp_next iter=%0d esc=%b tag=%h required %0d/%b/00777",
                               out_iter, out_escaped, out_tag, it, esc);
        end
        handshake();
    endtask

    task automatic test_abort();
        int lat; bit ok, okr, seen;
        send(0, 0, 0, 0, 100, 20'h00001, ok);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_iter vld=%b rdy=%b required 0/1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; seen |= out_valid; end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_result out_valid_seen=%b required 0", seen);
        end
        // abort while idle must not block an accept
        abort = 1'b1;
        send(0, 0, 0, 0, 3, 20'h00002, ok);
        abort = 1'b0;
        wait_result(20, lat, okr);
        checks++;
        if (!okr || out_iter !== IW'(3) || out_escaped !== 1'b0 || out_tag !== 20'h00002) begin
            errors++; $display("FAIL abort_follow iter=%0d esc=%b tag=%h required 3/0/00002",
                               out_iter, out_escaped, out_tag);
        end
        // abort beats out_ready while a result is pending
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_done vld=%b rdy=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit ok, okr;
        send(0, 0, 0, 0, 100, 20'h00003, ok);
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid_async vld=%b rdy=%b required 0/0", out_valid, in_ready);
        end
        #4 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle rdy=%b vld=%b required 1/0", in_ready, out_valid);
        end
        send(0, 0, 0, 0, 3, 20'h00004, ok);
        wait_result(20, lat, okr);
        checks++;
        if (!okr || out_iter !== IW'(3) || out_escaped !== 1'b0 || out_tag !== 20'h00004) begin
            errors++; $display("FAIL reset_mid_follow iter=%0d esc=%b tag=%h required 3/0/00004",
                               out_iter, out_escaped, out_tag);
        end
        handshake();
    endtask

    // Continuous valid and ready: accepts must be spaced max_iter+3 cycles apart.
    task automatic test_back_to_back();
        int acc_cyc[$];
        int cyc = 0;
        bit acc;
        drive_point(0, 0, 0, 0, 4, 20'h00005);
        in_valid = 1'b1; out_ready = 1'b1;
        while (acc_cyc.size() < 3 && cyc < 100) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) acc_cyc.push_back(cyc);
        end
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (acc_cyc.size() != 3) begin
            errors++; $display("FAIL b2b_accepts count=%0d required 3", acc_cyc.size());
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 7 || acc_cyc[2] - acc_cyc[1] !== 7) begin
                errors++; $display("FAIL b2b_spacing gaps=%0d,%0d required 7,7",
                                   acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    task automatic test_random();
        longint cr, ci, zr, zi;
        int mx, it, lat; bit esc, ok, okr;
        logic [TW-1:0] tg;
        for (int n = 0; n < 40; n++) begin
            cr = rnd_fx((5 * ONE) / 2);
            ci = rnd_fx((3 * ONE) / 2);
            zr = ($urandom_range(0, 1) == 0) ? 0 : rnd_fx((3 * ONE) / 2);
            zi = (zr == 0) ? 0 : rnd_fx((3 * ONE) / 2);
            mx = int'($urandom_range(0, 40));
            tg = TW'($urandom);
            model(cr, ci, zr, zi, mx, it, esc);
            send(cr, ci, zr, zi, mx, tg, ok);
            wait_result(mx + 10, lat, okr);
            checks++;
            if (!ok || !okr || int'(out_iter) !== it || out_escaped !== esc ||
                out_tag !== tg || lat !== it + 1) begin
                errors++;
                $display("FAIL random[%0d] iter=%0d esc=%b tag=%h lat=%0d required %0d/%b/%h/%0d",
                         n, out_iter, out_escaped, out_tag, lat, it, esc, tg, it + 1);
            end
            if (int'($urandom_range(0, 3)) == 0) repeat (int'($urandom_range(1, 4))) @(posedge clk);
            #0 handshake();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout sim_time=%0t required completion", $time);
        $fatal(1);
    end

endmodule
